decode_issue_stage: RTL and testbench

- Parametrised RV64I decode/issue stage between fetch latch (DE) and execute latch (EXE).
- Generates immediates and resolves operands from an external register file, with MEM/WB forwarding.
- Detects load-use and RAW hazards, and holds branch/jump issue until resolved.
- Valid/ready handshake on both sides; registered outputs to EXE.

---
 rtl/rv_pkg.sv | 40 ++++
 rtl/imm_gen.sv | 62 ++++++
 rtl/decode_issue_stage.sv | 145 ++++++++++++++
 tb/tb_decode_issue_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV64I decode constants: major opcodes, special encodings and
// immediate-format tags used by the decode/issue stage.
package rv_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] NOP_IR   = 32'h0000_0013;
  localparam logic [31:0] ECALL_IR = 32'h0000_0073;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_SH
  } imm_fmt_t;

  function automatic logic is_legal_opcode(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32, OPC_LOAD, OPC_STORE,
      OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM:
        is_legal_opcode = 1'b1;
      default:
        is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: extracts and sign-extends the RV64I
// immediate of an instruction and reports which format it used.
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt
);

  logic [63:0] imm64;

  always_comb begin
    imm64 = '0;
    fmt   = FMT_I;
    case (ir[6:0])
      OPC_OP_IMM: begin
        // funct3 001/101 are the shifts; their shamt width follows XLEN
        if (ir[13:12] == 2'b01) begin
          fmt   = FMT_SH;
          imm64 = (XLEN == 64) ? {58'd0, ir[25:20]} : {59'd0, ir[24:20]};
        end else begin
          imm64 = {{52{ir[31]}}, ir[31:20]};
        end
      end
      OPC_OP_IMM_32: begin
        if (ir[13:12] == 2'b01) begin
          fmt   = FMT_SH;
          imm64 = {59'd0, ir[24:20]};
        end else begin
          imm64 = {{52{ir[31]}}, ir[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        imm64 = {{52{ir[31]}}, ir[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm64 = {{52{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm64 = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm64 = {{32{ir[31]}}, ir[31:12], 12'd0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm64 = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      default: begin
        imm64 = '0;
      end
    endcase
    imm = imm64[XLEN-1:0];
  end

endmodule

// File: rtl/decode_issue_stage.sv
// RV64I decode/issue stage: resolves operands with MEM/WB forwarding, stalls on
// load-use / RAW hazards and outstanding control transfers, and registers the EXE latch.
module decode_issue_stage
  import rv_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int REG_AW  = 5,
  parameter bit FWD_EN  = 1'b1,
  parameter bit BR_HOLD = 1'b1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              de_v,
  input  logic [31:0]       de_ir,
  input  logic [XLEN-1:0]   de_npc,
  output logic              de_ready,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  input  logic [XLEN-1:0]   rf_d1,
  input  logic [XLEN-1:0]   rf_d2,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_drid,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_drid,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              br_resolved,
  input  logic              exe_ready,
  output logic              exe_v,
  output logic [31:0]       exe_ir,
  output logic [XLEN-1:0]   exe_npc,
  output logic [XLEN-1:0]   exe_op1,
  output logic [XLEN-1:0]   exe_op2,
  output logic [XLEN-1:0]   exe_imm,
  output logic              exe_ecall,
  output logic              exe_illegal
);

  logic [6:0]             opcode;
  logic [REG_AW-1:0]      rd;
  logic [XLEN-1:0]        imm;
  imm_fmt_t               fmt;
  logic [1:0][REG_AW-1:0] rs;
  logic [1:0][XLEN-1:0]   src_rf;
  logic [1:0][XLEN-1:0]   src_val;
  logic [1:0]             uses;
  logic [1:0]             src_haz;
  logic                   legal, is_ctrl, is_load, writes;
  logic                   hazard, br_block, issue;

  // EXE-pending record describing the instruction currently in the EXE latch
  logic [REG_AW-1:0]      ex_drid;
  logic                   ex_load;
  logic                   ex_wr;
  logic                   br_pend;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ir  (de_ir),
    .imm (imm),
    .fmt (fmt)
  );

  assign opcode  = de_ir[6:0];
  assign rd      = de_ir[7 +: REG_AW];
  assign rs[0]   = de_ir[15 +: REG_AW];
  assign rs[1]   = de_ir[20 +: REG_AW];
  assign rf_rs1  = rs[0];
  assign rf_rs2  = rs[1];
  assign src_rf  = {rf_d2, rf_d1};

  assign legal   = is_legal_opcode(opcode);
  assign uses[0] = !(fmt == FMT_U || fmt == FMT_J);
  assign uses[1] = (opcode == OPC_OP) || (opcode == OPC_OP_32) || (fmt == FMT_S) || (fmt == FMT_B);
  assign is_ctrl = (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
  assign is_load = (opcode == OPC_LOAD);
  assign writes  = legal && (rd != '0) && (opcode != OPC_STORE) && (opcode != OPC_BRANCH);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_val[gi] =
        (rs[gi] == '0)                                ? '0       :
        (FWD_EN && mem_wr && (mem_drid == rs[gi]))    ? mem_data :
        (FWD_EN && wb_wr  && (wb_drid  == rs[gi]))    ? wb_data  :
                                                        src_rf[gi];

      // Without forwarding every in-flight writer of a used source must retire first
      assign src_haz[gi] = uses[gi] && (rs[gi] != '0) && (FWD_EN ?
        (exe_v && ex_load && (ex_drid == rs[gi])) :
        ((exe_v && ex_wr && (ex_drid == rs[gi])) ||
         (mem_wr && (mem_drid == rs[gi])) ||
         (wb_wr  && (wb_drid  == rs[gi]))));
    end
  endgenerate

  assign hazard   = |src_haz;
  assign br_block = br_pend && !br_resolved;
  assign de_ready = !hazard && !br_block && (!exe_v || exe_ready);
  assign issue    = de_v && de_ready && !flush;

  always_ff @(posedge CLK) begin
    if (reset) begin
      exe_v       <= 1'b0;
      exe_ir      <= NOP_IR;
      exe_npc     <= '0;
      exe_op1     <= '0;
      exe_op2     <= '0;
      exe_imm     <= '0;
      exe_ecall   <= 1'b0;
      exe_illegal <= 1'b0;
      ex_drid     <= '0;
      ex_load     <= 1'b0;
      ex_wr       <= 1'b0;
      br_pend     <= 1'b0;
    end else begin
      if (flush) begin
        exe_v <= 1'b0;
      end else if (issue) begin
        exe_v       <= 1'b1;
        exe_ir      <= de_ir;
        exe_npc     <= de_npc;
        exe_op1     <= src_val[0];
        exe_op2     <= uses[1] ? src_val[1] : imm;
        exe_imm     <= imm;
        exe_ecall   <= (de_ir == ECALL_IR);
        exe_illegal <= !legal;
        ex_drid     <= rd;
        ex_load     <= is_load;
        ex_wr       <= writes;
      end else if (exe_ready) begin
        exe_v <= 1'b0;
      end

      if (flush) begin
        br_pend <= 1'b0;
      end else if (issue) begin
        br_pend <= BR_HOLD && is_ctrl;
      end else if (br_resolved) begin
        br_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: a vector table for decode/forwarding plus
// hand sequences for load-use, RAW without forwarding, branch hold, back-pressure, flush, reset.
module tb_decode_issue_stage;

  logic        CLK = 1'b0;
  logic        reset, de_v, flush, br_resolved, exe_ready, mem_wr, wb_wr;
  logic [31:0] de_ir;
  logic [63:0] de_npc, mem_data, wb_data;
  logic [4:0]  mem_drid, wb_drid;

  logic        de_ready, exe_v, exe_ecall, exe_illegal;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [63:0] rf_d1, rf_d2, exe_npc, exe_op1, exe_op2, exe_imm;
  logic [31:0] exe_ir;

  logic        nf_de_ready, nf_exe_v, nf_exe_ecall, nf_exe_illegal;
  logic [4:0]  nf_rf_rs1, nf_rf_rs2;
  logic [63:0] nf_rf_d1, nf_rf_d2, nf_exe_npc, nf_exe_op1, nf_exe_op2, nf_exe_imm;
  logic [31:0] nf_exe_ir;

  int total = 0;
  int bad   = 0;

  // Register file stand-in: x[n] reads as 0x1000+n on port 1 and 0x2000+n on port 2
  assign rf_d1    = 64'h1000 + {59'd0, rf_rs1};
  assign rf_d2    = 64'h2000 + {59'd0, rf_rs2};
  assign nf_rf_d1 = 64'h1000 + {59'd0, nf_rf_rs1};
  assign nf_rf_d2 = 64'h2000 + {59'd0, nf_rf_rs2};

  always #5 CLK = ~CLK;

  decode_issue_stage u_dut (
    .CLK(CLK), .reset(reset), .de_v(de_v), .de_ir(de_ir), .de_npc(de_npc),
    .de_ready(de_ready), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_d1(rf_d1), .rf_d2(rf_d2),
    .mem_wr(mem_wr), .mem_drid(mem_drid), .mem_data(mem_data),
    .wb_wr(wb_wr), .wb_drid(wb_drid), .wb_data(wb_data),
    .flush(flush), .br_resolved(br_resolved), .exe_ready(exe_ready),
    .exe_v(exe_v), .exe_ir(exe_ir), .exe_npc(exe_npc), .exe_op1(exe_op1),
    .exe_op2(exe_op2), .exe_imm(exe_imm), .exe_ecall(exe_ecall), .exe_illegal(exe_illegal)
  );

  decode_issue_stage #(.FWD_EN(1'b0)) u_nf (
    .CLK(CLK), .reset(reset), .de_v(de_v), .de_ir(de_ir), .de_npc(de_npc),
    .de_ready(nf_de_ready), .rf_rs1(nf_rf_rs1), .rf_rs2(nf_rf_rs2), .rf_d1(nf_rf_d1), .rf_d2(nf_rf_d2),
    .mem_wr(mem_wr), .mem_drid(mem_drid), .mem_data(mem_data),
    .wb_wr(wb_wr), .wb_drid(wb_drid), .wb_data(wb_data),
    .flush(flush), .br_resolved(br_resolved), .exe_ready(exe_ready),
    .exe_v(nf_exe_v), .exe_ir(nf_exe_ir), .exe_npc(nf_exe_npc), .exe_op1(nf_exe_op1),
    .exe_op2(nf_exe_op2), .exe_imm(nf_exe_imm), .exe_ecall(nf_exe_ecall), .exe_illegal(nf_exe_illegal)
  );

  typedef struct {
    logic [31:0] ir;
    logic        mwr;
    logic [4:0]  mid;
    logic [63:0] mdat;
    logic        wwr;
    logic [4:0]  wid;
    logic [63:0] wdat;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] imm;
    logic        ecall;
    logic        illegal;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  localparam logic [31:0] LD_X7   = 32'h0000B383;  // ld   x7,0(x1)
  localparam logic [31:0] ADD_X8  = 32'h00138433;  // add  x8,x7,x1
  localparam logic [31:0] ADD_X11 = 32'h000185B3;  // add  x11,x3,x0
  localparam logic [31:0] BEQ     = 32'hFE208CE3;  // beq  x1,x2,-8
  localparam logic [31:0] ADDI    = 32'hFE010113;  // addi sp,sp,-32
  localparam logic [31:0] JAL     = 32'h010000EF;  // jal  x1,16
  localparam logic [31:0] ECALL   = 32'h00000073;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_exe_v"},   {63'd0, exe_v}, 64'd0);
    chk({tag, "_exe_ir"},  {32'd0, exe_ir}, 64'h13);
    chk({tag, "_npc"},     exe_npc, 64'd0);
    chk({tag, "_op1"},     exe_op1, 64'd0);
    chk({tag, "_op2"},     exe_op2, 64'd0);
    chk({tag, "_imm"},     exe_imm, 64'd0);
    chk({tag, "_ecall"},   {63'd0, exe_ecall}, 64'd0);
    chk({tag, "_illegal"}, {63'd0, exe_illegal}, 64'd0);
    $display("%s: exe_v=%b exe_ir=%h", tag, exe_v, exe_ir);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; de_v = 1'b0; de_ir = 32'h13; de_npc = '0;
    mem_wr = 1'b0; mem_drid = '0; mem_data = '0;
    wb_wr = 1'b0; wb_drid = '0; wb_data = '0;
    flush = 1'b0; br_resolved = 1'b0; exe_ready = 1'b1;

    //            ir            mwr   mid    mdat    wwr   wid    wdat    op1                    op2                    imm                    ec    il
    vecs[0] = '{32'hFE010113, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  64'h1002,             64'hFFFFFFFFFFFFFFE0, 64'hFFFFFFFFFFFFFFE0, 1'b0, 1'b0};
    vecs[1] = '{32'h006284B3, 1'b1, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB, 64'hAA,               64'h2006,             64'h0,                1'b0, 1'b0};
    vecs[2] = '{32'h00600533, 1'b1, 5'd0, 64'hCC, 1'b1, 5'd6, 64'hBB, 64'h0,                64'hBB,               64'h0,                1'b0, 1'b0};
    vecs[3] = '{32'h00000073, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  64'h0,                64'h0,                64'h0,                1'b1, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  64'h101F,             64'h0,                64'h0,                1'b0, 1'b1};
    vecs[5] = '{32'hFE613E23, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  64'h1002,             64'h2006,             64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
    vecs[6] = '{32'h800000B7, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  64'h0,                64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0, 1'b0};
    vecs[7] = '{32'h02119213, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  64'h1003,             64'h21,               64'h21,               1'b0, 1'b0};
    vecs[8] = '{32'h4051D21B, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  64'h1003,             64'h5,                64'h5,                1'b0, 1'b0};

    tick(); tick();
    reset = 1'b0;
    #1;
    chk_reset("reset");
    chk("reset_de_ready", {63'd0, de_ready}, 64'd1);

    for (int i = 0; i < NV; i++) begin
      logic [63:0] npc;
      npc = 64'h8000_0000 + 64'(i * 4);
      de_v = 1'b1; de_ir = vecs[i].ir; de_npc = npc;
      mem_wr = vecs[i].mwr; mem_drid = vecs[i].mid; mem_data = vecs[i].mdat;
      wb_wr = vecs[i].wwr; wb_drid = vecs[i].wid; wb_data = vecs[i].wdat;
      #1;
      chk("vec_de_ready", {63'd0, de_ready}, 64'd1);
      tick();
      chk("vec_exe_v",   {63'd0, exe_v}, 64'd1);
      chk("vec_exe_ir",  {32'd0, exe_ir}, {32'd0, vecs[i].ir});
      chk("vec_exe_npc", exe_npc, npc);
      chk("vec_op1",     exe_op1, vecs[i].op1);
      chk("vec_op2",     exe_op2, vecs[i].op2);
      chk("vec_imm",     exe_imm, vecs[i].imm);
      chk("vec_ecall",   {63'd0, exe_ecall}, {63'd0, vecs[i].ecall});
      chk("vec_illegal", {63'd0, exe_illegal}, {63'd0, vecs[i].illegal});
      $display("vec %0d: ir=%h op1=%h op2=%h imm=%h", i, exe_ir, exe_op1, exe_op2, exe_imm);
    end
    de_v = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0;
    tick();

    // Load-use: one-cycle stall with a bubble, then issue with the load forwarded from MEM
    de_v = 1'b1; de_ir = LD_X7;
    tick();
    chk("lu_load_issued", {32'd0, exe_ir}, {32'd0, LD_X7});
    de_ir = ADD_X8;
    #1;
    chk("lu_stall_ready", {63'd0, de_ready}, 64'd0);
    tick();
    chk("lu_bubble_v", {63'd0, exe_v}, 64'd0);
    mem_wr = 1'b1; mem_drid = 5'd7; mem_data = 64'h77;
    #1;
    chk("lu_ready_again", {63'd0, de_ready}, 64'd1);
    tick();
    chk("lu_issue_ir",  {32'd0, exe_ir}, {32'd0, ADD_X8});
    chk("lu_issue_op1", exe_op1, 64'h77);
    chk("lu_issue_op2", exe_op2, 64'h2001);
    $display("load-use: exe_ir=%h op1=%h", exe_ir, exe_op1);
    de_v = 1'b0; mem_wr = 1'b0;
    tick();

    // Branch hold: blocked until br_resolved; resolve and issue in the same cycle
    de_v = 1'b1; de_ir = BEQ;
    tick();
    chk("br_exe_ir",  {32'd0, exe_ir}, {32'd0, BEQ});
    chk("br_imm",     exe_imm, 64'hFFFFFFFFFFFFFFF8);
    chk("br_op2",     exe_op2, 64'h2002);
    de_ir = ADDI;
    #1;
    chk("br_hold_ready0", {63'd0, de_ready}, 64'd0);
    tick();
    chk("br_hold_bubble", {63'd0, exe_v}, 64'd0);
    chk("br_hold_ready1", {63'd0, de_ready}, 64'd0);
    tick();
    chk("br_hold_bubble2", {63'd0, exe_v}, 64'd0);
    br_resolved = 1'b1;
    #1;
    chk("br_resolve_ready", {63'd0, de_ready}, 64'd1);
    tick();
    br_resolved = 1'b0;
    chk("br_resolve_issue_v",  {63'd0, exe_v}, 64'd1);
    chk("br_resolve_issue_ir", {32'd0, exe_ir}, {32'd0, ADDI});
    #1;
    chk("br_cleared_ready", {63'd0, de_ready}, 64'd1);
    $display("branch hold: exe_ir=%h de_ready=%b", exe_ir, de_ready);

    // Back-pressure on a JAL, then flush mid-stall
    de_ir = JAL; de_npc = 64'h9000;
    tick();
    chk("jal_ir",  {32'd0, exe_ir}, {32'd0, JAL});
    chk("jal_imm", exe_imm, 64'h10);
    chk("jal_op2", exe_op2, 64'h10);
    exe_ready = 1'b0; de_ir = ADDI; de_npc = 64'hA000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_exe_v",   {63'd0, exe_v}, 64'd1);
      chk("bp_exe_ir",  {32'd0, exe_ir}, {32'd0, JAL});
      chk("bp_exe_npc", exe_npc, 64'h9000);
      chk("bp_ready",   {63'd0, de_ready}, 64'd0);
      $display("backpressure %0d: exe_ir=%h npc=%h", k, exe_ir, exe_npc);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_exe_v", {63'd0, exe_v}, 64'd0);
    #1;
    chk("flush_br_pend_clear", {63'd0, de_ready}, 64'd1);
    tick();
    chk("post_flush_issue", {32'd0, exe_ir}, {32'd0, ADDI});
    exe_ready = 1'b1; de_ir = ECALL; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_no_issue_v",  {63'd0, exe_v}, 64'd0);
    chk("flush_no_issue_ir", {32'd0, exe_ir}, {32'd0, ADDI});
    tick();
    chk("ecall_flag", {63'd0, exe_ecall}, 64'd1);
    $display("flush: exe_v=%b exe_ecall=%b", exe_v, exe_ecall);

    // Reset wins over flush and a valid DE instruction
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; de_v = 1'b0;
    chk_reset("reset_flush");

    // No forwarding: stall until the MEM then WB writer of x3 have retired
    de_v = 1'b1; de_ir = ADD_X11;
    mem_wr = 1'b1; mem_drid = 5'd3; mem_data = 64'h33;
    #1;
    chk("nf_stall_mem", {63'd0, nf_de_ready}, 64'd0);
    tick();
    chk("nf_exe_v_mem", {63'd0, nf_exe_v}, 64'd0);
    mem_wr = 1'b0; wb_wr = 1'b1; wb_drid = 5'd3; wb_data = 64'h33;
    #1;
    chk("nf_stall_wb", {63'd0, nf_de_ready}, 64'd0);
    tick();
    chk("nf_exe_v_wb", {63'd0, nf_exe_v}, 64'd0);
    wb_wr = 1'b0;
    #1;
    chk("nf_ready", {63'd0, nf_de_ready}, 64'd1);
    tick();
    de_v = 1'b0;
    chk("nf_issue_v",   {63'd0, nf_exe_v}, 64'd1);
    chk("nf_issue_ir",  {32'd0, nf_exe_ir}, {32'd0, ADD_X11});
    chk("nf_issue_op1", nf_exe_op1, 64'h1003);
    $display("no-forward: exe_ir=%h op1=%h", nf_exe_ir, nf_exe_op1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
